// File: rtl/eth_phy_10g_rx_frame_sync_if.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync_if
//   Groups the signals between the 10G RX gearbox/SERDES and the frame sync
//   block.
//
//   Protocol: serdes_rx_hdr is meaningful only in cycles where
//   serdes_rx_hdr_valid is high. There is no ready/backpressure: the sync
//   block samples every qualified header on the rising edge or discards it
//   during a slip. serdes_rx_bitslip and rx_block_lock are level signals
//   driven from registers.
//
//   Signals:
//     serdes_rx_hdr        sync header from gearbox  (master -> slave)
//     serdes_rx_hdr_valid  header qualifier          (master -> slave)
//     serdes_rx_bitslip    slip request to SERDES    (slave -> master)
//     rx_block_lock        block lock status         (slave -> master)
// ---------------------------------------------------------------------------
interface eth_phy_10g_rx_frame_sync_if #(
    parameter int HDR_WIDTH = 2
);
    logic [HDR_WIDTH-1:0] serdes_rx_hdr;
    logic                 serdes_rx_hdr_valid;
    logic                 serdes_rx_bitslip;
    logic                 rx_block_lock;

    // Gearbox / SERDES side
    modport master (
        output serdes_rx_hdr,
        output serdes_rx_hdr_valid,
        input  serdes_rx_bitslip,
        input  rx_block_lock
    );

    // Frame sync side
    modport slave (
        input  serdes_rx_hdr,
        input  serdes_rx_hdr_valid,
        output serdes_rx_bitslip,
        output rx_block_lock
    );
endinterface

// File: rtl/eth_phy_10g_rx_frame_sync.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync
//   64b/66b block lock state machine. Qualified sync headers are examined in
//   windows of 64. Lock is acquired after 64 consecutive valid headers and
//   dropped after 16 invalid headers within one window. Any invalid header
//   while unlocked, or loss of lock, requests a bit slip from the SERDES,
//   followed by a settle period during which headers are ignored.
//
//   Ports:
//     clk                   rising-edge clock
//     rst_n                 synchronous active-low reset
//     bus (slave)           serdes_rx_hdr / serdes_rx_hdr_valid in,
//                           serdes_rx_bitslip / rx_block_lock out
//     dbg_state             FSM state (0 sync, 1 slip high, 2 slip low)
//     dbg_sh_count          headers seen in current window
//     dbg_sh_invalid_count  invalid headers seen in current window
// ---------------------------------------------------------------------------
module eth_phy_10g_rx_frame_sync #(
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    eth_phy_10g_rx_frame_sync_if.slave   bus,
    output logic [1:0]                   dbg_state,
    output logic [5:0]                   dbg_sh_count,
    output logic [3:0]                   dbg_sh_invalid_count
);

    generate
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_10g_rx_frame_sync: HDR_WIDTH must be 2");
        end
        if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
            $error("eth_phy_10g_rx_frame_sync: BITSLIP_HIGH_CYCLES must be 1..255");
        end
        if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
            $error("eth_phy_10g_rx_frame_sync: BITSLIP_LOW_CYCLES must be 0..255");
        end
    endgenerate

    localparam logic [7:0] HIGH_LAST = 8'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [7:0] LOW_LAST  = 8'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_SLIP_HIGH = 2'd1,
        ST_SLIP_LOW  = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] slip_cnt, slip_cnt_next;
    logic [5:0] sh_count, sh_count_next;
    logic [3:0] sh_invalid_count, sh_invalid_count_next;
    logic       bitslip_q, bitslip_next;
    logic       lock_q, lock_next;

    logic hdr_qual;
    logic hdr_ok;
    logic window_last;
    logic invalid_last;
    logic slip_start;

    // Headers only count in SYNC; slip phases discard them.
    assign hdr_qual     = (state == ST_SYNC) && bus.serdes_rx_hdr_valid;
    assign hdr_ok       = (bus.serdes_rx_hdr == 2'b01) || (bus.serdes_rx_hdr == 2'b10);
    assign window_last  = (sh_count == 6'd63);
    assign invalid_last = (sh_invalid_count == 4'd15);
    // Unlocked: any bad header slips. Locked: only the 16th bad one does,
    // which also wins over the 64th-header window close.
    assign slip_start   = hdr_qual && !hdr_ok && (!lock_q || invalid_last);

    // State register (also holds the registered outputs and counters)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_SYNC;
            slip_cnt         <= 8'd0;
            sh_count         <= 6'd0;
            sh_invalid_count <= 4'd0;
            bitslip_q        <= 1'b0;
            lock_q           <= 1'b0;
        end else begin
            state            <= state_next;
            slip_cnt         <= slip_cnt_next;
            sh_count         <= sh_count_next;
            sh_invalid_count <= sh_invalid_count_next;
            bitslip_q        <= bitslip_next;
            lock_q           <= lock_next;
        end
    end

    // Next-state logic; slip_cnt times the two slip phases and runs
    // independently of serdes_rx_hdr_valid.
    always_comb begin
        state_next    = state;
        slip_cnt_next = slip_cnt;
        case (state)
            ST_SYNC: begin
                if (slip_start) begin
                    state_next    = ST_SLIP_HIGH;
                    slip_cnt_next = 8'd0;
                end
            end
            ST_SLIP_HIGH: begin
                if (slip_cnt == HIGH_LAST) begin
                    state_next    = (BITSLIP_LOW_CYCLES == 0) ? ST_SYNC : ST_SLIP_LOW;
                    slip_cnt_next = 8'd0;
                end else begin
                    slip_cnt_next = slip_cnt + 8'd1;
                end
            end
            ST_SLIP_LOW: begin
                if (slip_cnt == LOW_LAST) begin
                    state_next    = ST_SYNC;
                    slip_cnt_next = 8'd0;
                end else begin
                    slip_cnt_next = slip_cnt + 8'd1;
                end
            end
            default: begin
                state_next    = ST_SYNC;
                slip_cnt_next = 8'd0;
            end
        endcase
    end

    // Output / counter logic
    always_comb begin
        sh_count_next         = sh_count;
        sh_invalid_count_next = sh_invalid_count;
        lock_next             = lock_q;
        // Registered so the pulse lines up exactly with the SLIP_HIGH phase.
        bitslip_next          = (state_next == ST_SLIP_HIGH);
        if (hdr_qual) begin
            if (slip_start) begin
                sh_count_next         = 6'd0;
                sh_invalid_count_next = 4'd0;
                lock_next             = 1'b0;
            end else if (window_last) begin
                // Window closes: lock is gained on a clean window, kept otherwise.
                sh_count_next         = 6'd0;
                sh_invalid_count_next = 4'd0;
                lock_next             = lock_q | (hdr_ok && (sh_invalid_count == 4'd0));
            end else begin
                sh_count_next = sh_count + 6'd1;
                if (!hdr_ok) begin
                    sh_invalid_count_next = sh_invalid_count + 4'd1;
                end
            end
        end
    end

    assign bus.serdes_rx_bitslip = bitslip_q;
    assign bus.rx_block_lock     = lock_q;
    assign dbg_state             = state;
    assign dbg_sh_count          = sh_count;
    assign dbg_sh_invalid_count  = sh_invalid_count;

endmodule

// File: doc/eth_phy_10g_rx_frame_sync.md
ETH_PHY_10G_RX_FRAME_SYNC -- requirements
Module: eth_phy_10g_rx_frame_sync

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width; any other value is an elaboration error.
REQ-002 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, cycles serdes_rx_bitslip is held high per slip (legal range 1..255).
REQ-003 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, settle cycles after each slip during which headers are ignored (legal range 0..255).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 serdes_rx_hdr  input  HDR_WIDTH  sync header from gearbox.
REQ-007 serdes_rx_hdr_valid  input  1  header qualifier; low cycles are ignored entirely.
REQ-008 serdes_rx_bitslip  output  1  registered slip request to SERDES.
REQ-009 rx_block_lock  output  1  registered block lock status; feeds the downstream RX watchdog.

Function
REQ-010 Valid header SHALL be 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-011 SHALL keep sh_count (6 bit) and sh_invalid_count (4 bit), both counting only qualified headers (serdes_rx_hdr_valid high, not in slip phase).
REQ-012 States: SYNC (examine headers), SLIP_HIGH (bitslip asserted), SLIP_LOW (bitslip deasserted, headers ignored).
REQ-013 SYNC, qualified valid header: sh_count increments; if sh_count was 63 (64th header) then rx_block_lock SHALL be set if sh_invalid_count is 0, and both counters SHALL clear.
REQ-014 SYNC, qualified invalid header, lock low: rx_block_lock stays 0, counters clear, SHALL move to SLIP_HIGH next cycle.
REQ-015 SYNC, qualified invalid header, lock high: both counters increment; if sh_invalid_count was 15 (16th invalid in window) rx_block_lock SHALL clear on the next edge, counters clear, move to SLIP_HIGH.
REQ-016 SYNC, lock high, 64th header of window reached with fewer than 16 invalid: lock SHALL remain 1, counters clear (no lock re-evaluation beyond REQ-013).
REQ-017 Simultaneous 64th header and 16th invalid: REQ-015 SHALL take priority (lock lost, slip).
REQ-018 SLIP_HIGH: serdes_rx_bitslip SHALL be 1 for exactly BITSLIP_HIGH_CYCLES cycles, then SLIP_LOW.
REQ-019 SLIP_LOW: serdes_rx_bitslip 0 for exactly BITSLIP_LOW_CYCLES cycles, then SYNC; if BITSLIP_LOW_CYCLES is 0, SHALL go directly to SYNC.
REQ-020 serdes_rx_hdr_valid low SHALL freeze counters and state in SYNC; slip-phase cycle counting SHALL proceed regardless of serdes_rx_hdr_valid.
REQ-021 Counter arithmetic SHALL never wrap: counters clear on the terminal events above before overflow.
REQ-022 Lock acquisition latency: rx_block_lock SHALL rise on the edge that samples the 64th consecutive qualified valid header.

Reset
REQ-023 rst_n low at a rising edge SHALL set state SYNC, counters 0, serdes_rx_bitslip 0, rx_block_lock 0, including mid-slip.
REQ-024 First header after rst_n rises SHALL be evaluated in SYNC with empty window.

Verification
REQ-025 After reset, 64 consecutive 2'b01/2'b10 headers -> rx_block_lock 0 after 63, 1 after 64th edge; serdes_rx_bitslip never asserted.
REQ-026 Unlocked, single 2'b11 header -> next cycle serdes_rx_bitslip 1 for 1 cycle, then 8 cycles of 0 with headers ignored (drive 2'b00 there: no effect), then 64 valid headers -> lock.
REQ-027 Locked, 15 invalid headers spread over one 64-header window -> lock stays 1, counters clear; next window, 16 invalid -> lock 0 on edge after 16th, one slip pulse.
REQ-028 Locked, serdes_rx_hdr_valid low for 100 cycles with 2'b00 on serdes_rx_hdr -> no change in lock, counters or bitslip.
REQ-029 rst_n low during SLIP_HIGH -> serdes_rx_bitslip 0 and rx_block_lock 0 on that edge; resumes in SYNC.
REQ-030 BITSLIP_HIGH_CYCLES=3, BITSLIP_LOW_CYCLES=0 -> invalid header while unlocked yields 3-cycle bitslip pulse, headers evaluated on the cycle immediately after.
